rr_response_router: RTL and testbench



---
 rtl/rr_response_router_pkg.sv | 13 +
 rtl/rr_id_fifo.sv | 58 +++++
 rtl/rr_response_router.sv | 102 ++++++++++
 tb/tb_rr_response_router.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/rr_response_router_pkg.sv
// Shared definitions for the round-robin arbiter / response-router pair:
// port-ID width helper and the default port-ID type.
package rr_response_router_pkg;

    function automatic int rr_port_w(input int num_ports);
        return (num_ports <= 1) ? 1 : $clog2(num_ports);
    endfunction

    localparam int RR_DEFAULT_NUM_PORTS = 2;

    typedef logic [rr_port_w(RR_DEFAULT_NUM_PORTS)-1:0] rr_port_id_t;

endpackage

// File: rtl/rr_id_fifo.sv
// Circular ID FIFO: push/pop with head-before-write semantics; a push into a
// full FIFO is accepted only when a pop frees a slot in the same cycle.
module rr_id_fifo
    import rr_response_router_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter int  WIDTH = 1,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count,
    output logic             full
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_pop_ok;
    logic             w_push_ok;

    assign w_pop_ok  = pop && (r_count != '0);
    assign w_push_ok = push && ((r_count != FULL_CNT) || w_pop_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset: stale IDs are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= din;
    end

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;
    assign full  = (r_count == FULL_CNT);

endmodule

// File: rtl/rr_response_router.sv
// Steers in-order responses back to the requester that issued them.
// Define RR_RESPONSE_ROUTER_OUTPUT_REG_EN to register the per-port outputs.
module rr_response_router
    import rr_response_router_pkg::*;
#(
    parameter int  NUM_PORTS       = 2,
    parameter int  MAX_OUTSTANDING = 4,
    parameter int  DATA_WIDTH      = 32,
    localparam int PORT_W          = rr_port_w(NUM_PORTS),
    localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue,
    input  logic [PORT_W-1:0]     issue_port,
    output logic                  full,
    output logic [CNT_W-1:0]      outstanding,
    input  logic                  rsp_valid,
    input  logic [DATA_WIDTH-1:0] rsp_data,
    output logic [NUM_PORTS-1:0]  port_rsp_valid,
    output logic [DATA_WIDTH-1:0] port_rsp_data,
    output logic                  overflow,
    output logic                  underflow
);

    logic [PORT_W-1:0]    w_head;
    logic [CNT_W-1:0]     w_count;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_pop;
    logic [NUM_PORTS-1:0] w_vld;
    logic                 r_overflow;
    logic                 r_underflow;

    rr_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (PORT_W)
    ) u_id_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (issue),
        .pop   (w_pop),
        .din   (issue_port),
        .head  (w_head),
        .count (w_count),
        .full  (w_full)
    );

    assign w_empty = (w_count == '0);
    assign w_pop   = rsp_valid && !w_empty;

    generate
        if (NUM_PORTS == 1) begin : g_single
            assign w_vld = NUM_PORTS'(w_pop);
        end else begin : g_multi
            always_comb begin
                w_vld = '0;
                for (int i = 0; i < NUM_PORTS; i++) begin
                    w_vld[i] = w_pop && (w_head == PORT_W'(i));
                end
            end
        end
    endgenerate

    // Both error flags are sticky until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (issue && w_full && !w_pop) r_overflow  <= 1'b1;
            if (rsp_valid && w_empty)      r_underflow <= 1'b1;
        end
    end

`ifdef RR_RESPONSE_ROUTER_OUTPUT_REG_EN
    logic [NUM_PORTS-1:0]  r_port_rsp_valid;
    logic [DATA_WIDTH-1:0] r_port_rsp_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_port_rsp_valid <= '0;
            r_port_rsp_data  <= '0;
        end else begin
            r_port_rsp_valid <= w_vld;
            r_port_rsp_data  <= rsp_data;
        end
    end

    assign port_rsp_valid = r_port_rsp_valid;
    assign port_rsp_data  = r_port_rsp_data;
`else
    assign port_rsp_valid = w_vld;
    assign port_rsp_data  = rsp_data;
`endif

    assign full        = w_full;
    assign outstanding = w_count;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;

endmodule

// File: tb/tb_rr_response_router.sv
// Scoreboard bench for rr_response_router (4 ports, depth 4): directed
// scenarios followed by randomized traffic against a queue-based model.
module tb_rr_response_router;

    localparam int NP = 4;
    localparam int MO = 4;
    localparam int DW = 32;
`ifdef RR_RESPONSE_ROUTER_OUTPUT_REG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          issue = 1'b0;
    logic [1:0]    issue_port = '0;
    logic          rsp_valid = 1'b0;
    logic [DW-1:0] rsp_data = '0;
    logic          full;
    logic [2:0]    outstanding;
    logic [NP-1:0] port_rsp_valid;
    logic [DW-1:0] port_rsp_data;
    logic          overflow;
    logic          underflow;

    rr_response_router #(
        .NUM_PORTS       (NP),
        .MAX_OUTSTANDING (MO),
        .DATA_WIDTH      (DW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .issue          (issue),
        .issue_port     (issue_port),
        .full           (full),
        .outstanding    (outstanding),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .port_rsp_valid (port_rsp_valid),
        .port_rsp_data  (port_rsp_data),
        .overflow       (overflow),
        .underflow      (underflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        int            cyc;
        logic [NP-1:0] vec;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sbq[$];
    int   mq[$];
    int   cur_cnt = 0, nxt_cnt = 0;
    bit   cur_ovf = 0, nxt_ovf = 0;
    bit   cur_unf = 0, nxt_unf = 0;
    int   vectors = 0;
    int   miscompares = 0;
    bit   mon_en = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Drive one cycle of stimulus and advance the reference model.
    task automatic step(input bit r, input bit iss, input int p, input bit rv,
                        input logic [DW-1:0] d);
        exp_t e;
        bit   popped;
        @(posedge clk);
        #1;
        cur_cnt = nxt_cnt;
        cur_ovf = nxt_ovf;
        cur_unf = nxt_unf;
        rst        = r;
        issue      = iss;
        issue_port = p[1:0];
        rsp_valid  = rv;
        rsp_data   = d;
        popped     = 0;
        if (r) begin
            mq.delete();
            nxt_cnt = 0;
            nxt_ovf = 0;
            nxt_unf = 0;
        end else begin
            if (rv) begin
                if (mq.size() == 0) begin
                    nxt_unf = 1;
                end else begin
                    e.cyc  = cyc + LAT;
                    e.vec  = NP'(1) << mq[0];
                    e.data = d;
                    sbq.push_back(e);
                    void'(mq.pop_front());
                    popped = 1;
                end
            end
            if (iss) begin
                if (mq.size() == MO && !popped) nxt_ovf = 1;
                else mq.push_back(p);
            end
            nxt_cnt = mq.size();
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, '0);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, '0);
        step(0, 0, 0, 0, '0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("outstanding", 64'(outstanding), 64'(cur_cnt));
            chk("full", 64'(full), 64'(cur_cnt == MO));
            chk("overflow", 64'(overflow), 64'(cur_ovf));
            chk("underflow", 64'(underflow), 64'(cur_unf));
            while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
                chk("missing_strobe", 64'(0), 64'(sbq[0].vec));
                void'(sbq.pop_front());
            end
            if (port_rsp_valid != '0) begin
                if (sbq.size() == 0 || sbq[0].cyc != cyc) begin
                    chk("unexpected_strobe", 64'(port_rsp_valid), 64'(0));
                end else begin
                    chk("strobe", 64'(port_rsp_valid), 64'(sbq[0].vec));
                    chk("data", 64'(port_rsp_data), 64'(sbq[0].data));
                    void'(sbq.pop_front());
                end
            end
        end
    end

    initial begin
        step(1, 0, 0, 0, '0);
        step(1, 0, 0, 0, '0);
        mon_en = 1;
        @(negedge clk);
        chk("rst_strobe", 64'(port_rsp_valid), 64'(0));
`ifdef RR_RESPONSE_ROUTER_OUTPUT_REG_EN
        chk("rst_data", 64'(port_rsp_data), 64'(0));
`endif

        // In-order routing across four ports.
        step(0, 1, 2, 0, '0);
        step(0, 1, 0, 0, '0);
        step(0, 1, 3, 0, '0);
        step(0, 1, 1, 0, '0);
        for (int k = 0; k < 4; k++) step(0, 0, 0, 1, DW'(32'hA + k));
        idle(2);

        // Full, issue+response while full, then overflow.
        for (int k = 0; k < 4; k++) step(0, 1, k, 0, '0);
        step(0, 1, 1, 1, 32'h11);
        step(0, 1, 2, 0, '0);
        for (int k = 0; k < 4; k++) step(0, 0, 0, 1, DW'(32'h20 + k));
        idle(1);
        do_reset();

        // Response with empty FIFO: sticky underflow.
        step(0, 0, 0, 1, 32'hDEAD);
        idle(3);
        do_reset();

        // Issue and response together on an empty FIFO.
        step(0, 1, 3, 1, 32'hBAD);
        step(0, 0, 0, 1, 32'h33);
        idle(1);

        // Reset mid-operation discards in-flight IDs.
        for (int k = 0; k < 3; k++) step(0, 1, k + 1, 0, '0);
        step(1, 0, 0, 0, '0);
        step(0, 0, 0, 1, 32'h44);
        idle(2);
        do_reset();

        // Randomized traffic.
        for (int k = 0; k < 500; k++) begin
            bit r;
            r = ($urandom_range(0, 99) < 2);
            if (r) step(1, 0, 0, 0, '0);
            else step(0, $urandom_range(0, 99) < 55, $urandom_range(0, NP - 1),
                      $urandom_range(0, 99) < 50, $urandom);
        end
        idle(4);

        while (sbq.size() > 0) begin
            chk("undelivered", 64'(0), 64'(sbq[0].vec));
            void'(sbq.pop_front());
        end
        mon_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
